uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Oversampling 8N1 serial receiver for the `rx_in` line. It is the receiving end of the framing that `snddata` drives on `tx_out`, and uses the same `choose` baud map. Each received byte goes into a 4-entry FIFO and is offered downstream on a valid/ready handshake. This lets the UART-to-display path absorb bursts from the PC without losing bytes while the consumer is busy.

## Interface
- `DIV0`, default 326: clocks per 1/16 bit at 9600 baud (50 MHz clock)
- `DIV1`, default 163: clocks per 1/16 bit at 19200 baud
- `DIV2`, default 81: clocks per 1/16 bit at 38400 baud
- `DIV3`, default 27: clocks per 1/16 bit at 115200 baud
- `clk` input 1: system clock; the only clock
- `rst` input 1: asynchronous, active-high reset
- `rx_in` input 1: serial line; idle high; asynchronous to `clk`
- `choose` input 2: baud select; 00→DIV0, 01→DIV1, 10→DIV2, 11→DIV3
- `rx_ready` input 1: consumer accepts the head byte this cycle
- `rx_valid` output 1: FIFO non-empty; `rx_data` is valid
- `rx_data` output 8: FIFO head byte
- `frame_err` output 1: one-cycle pulse when a bad stop bit is seen
- `overrun` output 1: one-cycle pulse when a byte is dropped because the FIFO is full

## Operation
- **Input synchronizer**
  - Two flops on `rx_in`, both reset to 1.
  - Everything downstream uses the synchronized signal `rxs`.
- **Tick generator**
  - A divider produces a one-cycle `tick` every DIVn clocks.
  - DIVn is latched from `choose` on entry to START and held until return to IDLE.
  - In IDLE the divider free-runs on the currently selected `choose` value.
- **Receive FSM** (`tcnt` is a 4-bit tick counter; `bitn` is a 3-bit bit index)
  - IDLE: when `rxs`=0, go to START, clear `tcnt`, restart the divider.
  - START: at `tcnt`=7, majority-vote the samples taken at ticks 6, 7, 8.
    - Vote 1: false start; return to IDLE.
    - Vote 0: go to DATA with `tcnt`=0 and `bitn`=0.
  - DATA: at `tcnt`=15, majority-vote the samples at ticks 14, 15, 0 of the next window, then shift the bit in LSB-first.
    - After `bitn`=7, go to STOP.
    - Sample position is therefore mid-bit: 16 ticks after the start-bit midpoint.
  - STOP: at the mid-bit majority point, evaluate the stop bit.
    - Stop = 1: push the shift register into the FIFO.
    - Stop = 0: pulse `frame_err` and discard the byte.
    - Return to IDLE in either case; there is no wait for the end of the stop bit, so a back-to-back start bit is not missed.
    - In IDLE after a framing error, a line held low is not treated as a new start until `rxs` has been seen high for at least one cycle.
- **FIFO**
  - 4 entries; 2-bit read and write pointers; 3-bit count.
  - `rx_valid` = (count ≠ 0); `rx_data` = mem[rd_ptr], a registered read of the head.
  - Pop when `rx_valid` && `rx_ready`.
  - Push and pop in the same cycle: both occur and count is unchanged. This also holds when full, and the byte is accepted.
  - Push when full with no pop: byte dropped, `overrun` pulses, FIFO contents unchanged.
  - Pointers wrap modulo 4.
- **Simultaneous events**
  - A framing error and an overrun cannot occur for the same byte; only a good frame can overrun.

## Timing
- **Reset values**
  - `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0.
  - FSM in IDLE, FIFO empty, synchronizer = 1.
- **Reset mid-frame**
  - The partial byte is lost and the FIFO is cleared.
  - After release, the first frame whose start edge follows release is received correctly.
- **Latency**
  - A `rx_in` edge reaches `rxs` after 2 clocks.
  - The stop-bit decision is made about 9.5 bit periods after the start edge.
  - `rx_valid` rises on the clock after the push edge.
  - `frame_err` and `overrun` are high for exactly the one cycle following the stop decision.
- **Handshake**
  - `rx_data` is stable while `rx_valid`=1 and `rx_ready`=0.
  - After a pop, the next entry is visible in the following cycle.
- **Tolerance**
  - Tolerates ±3% baud mismatch at every `choose` setting.
- **Baud change**
  - A change of `choose` mid-frame has no effect on the current frame.

## Test plan
- **Basic receive:** `choose`=11, send 0x55 then 0xA3 back-to-back (single stop bit), `rx_ready`=1 → two accepted handshakes with `rx_data` 0x55 then 0xA3; no `frame_err`, no `overrun`.
- **False start:** at `choose`=00, pulse `rx_in` low for 4×DIV0 clocks, then send 0x3C → no byte from the glitch; 0x3C received.
- **Framing error:** send 0x81 with stop bit = 0 → `frame_err` pulses once; `rx_valid` stays 0. A following 0x7E is received correctly.
- **Overrun:** `rx_ready`=0, send 0x01..0x05 → `overrun` pulses once on 0x05. Then `rx_ready`=1 drains 0x01, 0x02, 0x03, 0x04 in order, and `rx_valid` drops.
- **Full with simultaneous pop:** with the FIFO full, assert `rx_ready` on the push cycle of a 6th byte → no `overrun`; 6th byte retained; count stays 4.
- **Reset and baud change:** assert `rst` in the middle of data bit 3 → outputs go to reset values immediately. Next, change `choose` 11→10 mid-frame → current byte still correct at 115200, and the next frame is received correctly at 38400.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 serial receiver with a 4-entry byte FIFO and valid/ready output.
// The baud divider is latched at start-bit detection so a baud change never disturbs a frame in flight.
module uart_rx_fifo #(
   parameter int DIV0 = 326,
   parameter int DIV1 = 163,
   parameter int DIV2 = 81,
   parameter int DIV3 = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic [1:0] choose,
   input  logic       rx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       frame_err,
   output logic       overrun
);
   localparam int DW = 16;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic logic [DW-1:0] div_of(input logic [1:0] c);
      case (c)
         2'b00:   div_of = DW'(DIV0);
         2'b01:   div_of = DW'(DIV1);
         2'b10:   div_of = DW'(DIV2);
         default: div_of = DW'(DIV3);
      endcase
   endfunction

   logic          sync1_reg, rxs;
   state_t        state_reg;
   logic [DW-1:0] div_cnt_reg, div_lat_reg, div_cur;
   logic          tick, start_det, vote, push, pop, push_ok, full;
   logic [3:0]    tcnt_reg;
   logic [2:0]    bitn_reg;
   logic [1:0]    samp_reg;
   logic [7:0]    shift_reg;
   logic          need_high_reg, frame_err_reg, overrun_reg;
   logic [1:0]    wr_ptr_reg, rd_ptr_reg, rd_next;
   logic [2:0]    count_reg, count_next;
   logic [7:0]    rx_data_reg;
   logic [7:0]    mem [0:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         rxs       <= 1'b1;
      end else begin
         sync1_reg <= rx_in;
         rxs       <= sync1_reg;
      end
   end

   // The divider follows choose only while idle; a frame runs on the latched value.
   assign div_cur   = (state_reg == IDLE) ? div_of(choose) : div_lat_reg;
   assign tick      = (div_cnt_reg >= div_cur - DW'(1));
   assign start_det = (state_reg == IDLE) && !rxs && !need_high_reg;
   assign vote      = (samp_reg[1] & samp_reg[0]) | (samp_reg[1] & rxs) | (samp_reg[0] & rxs);
   assign push      = (state_reg == STOP) && tick && (tcnt_reg == 4'd15) && vote;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt_reg <= '0;
      else if (start_det || tick)
         div_cnt_reg <= '0;
      else
         div_cnt_reg <= div_cnt_reg + DW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         tcnt_reg      <= '0;
         bitn_reg      <= '0;
         samp_reg      <= 2'b11;
         shift_reg     <= '0;
         need_high_reg <= 1'b1;
         frame_err_reg <= 1'b0;
         div_lat_reg   <= DW'(DIV0);
      end else begin
         frame_err_reg <= 1'b0;
         if (rxs)
            need_high_reg <= 1'b0;
         if (tick)
            samp_reg <= {samp_reg[0], rxs};
         case (state_reg)
            IDLE: begin
               if (start_det) begin
                  state_reg   <= START;
                  tcnt_reg    <= '0;
                  div_lat_reg <= div_of(choose);
               end
            end
            START: begin
               if (tick) begin
                  if (tcnt_reg == 4'd7) begin
                     tcnt_reg <= '0;
                     bitn_reg <= '0;
                     state_reg <= vote ? IDLE : DATA;
                  end else begin
                     tcnt_reg <= tcnt_reg + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  tcnt_reg <= tcnt_reg + 4'd1;
                  if (tcnt_reg == 4'd15) begin
                     shift_reg <= {vote, shift_reg[7:1]};
                     bitn_reg  <= bitn_reg + 3'd1;
                     if (bitn_reg == 3'd7)
                        state_reg <= STOP;
                  end
               end
            end
            default: begin
               if (tick) begin
                  tcnt_reg <= tcnt_reg + 4'd1;
                  if (tcnt_reg == 4'd15) begin
                     state_reg <= IDLE;
                     if (!vote) begin
                        frame_err_reg <= 1'b1;
                        need_high_reg <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign rx_valid   = (count_reg != 3'd0);
   assign full       = (count_reg == 3'd4);
   assign pop        = rx_valid && rx_ready;
   assign push_ok    = push && (!full || pop);
   assign rd_next    = pop ? rd_ptr_reg + 2'd1 : rd_ptr_reg;
   assign count_next = count_reg + {2'b00, push_ok} - {2'b00, pop};

   for (genvar gi = 0; gi < 4; gi++) begin : g_mem
      always_ff @(posedge clk) begin
         if (push_ok && (wr_ptr_reg == 2'(gi)))
            mem[gi] <= shift_reg;
      end
   end

   // Head register looks ahead to the next read pointer, bypassing a byte written straight to the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         rx_data_reg <= '0;
         overrun_reg <= 1'b0;
      end else begin
         overrun_reg <= push && full && !pop;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         rd_ptr_reg <= rd_next;
         count_reg  <= count_next;
         if (count_next != 3'd0)
            rx_data_reg <= (push_ok && (wr_ptr_reg == rd_next)) ? shift_reg : mem[rd_next];
      end
   end

   assign rx_data   = rx_data_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven on rx_in, expected bytes queued at send time
// and compared against bytes accepted on the valid/ready handshake.
module tb_uart_rx_fifo;
   localparam int D0 = 20;
   localparam int D1 = 12;
   localparam int D2 = 6;
   localparam int D3 = 4;

   logic       clk = 1'b0;
   logic       rst, rx_in, rx_ready;
   logic [1:0] choose;
   logic       rx_valid, frame_err, overrun;
   logic [7:0] rx_data;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int pass_cnt = 0;
   int total = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int cyc = 0;
   int ov_cyc = 0;
   int last_start = 0;
   int pop_off = 0;

   uart_rx_fifo #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .choose(choose), .rx_ready(rx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            $display("accept byte %02h at cycle %0d", rx_data, cyc);
         end
         if (frame_err) fe_cnt++;
         if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_bit, input logic expect_it);
      @(posedge clk); #1;
      rx_in = 1'b0;
      last_start = cyc;
      if (expect_it) exp_q.push_back(b);
      repeat (bit_clks) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_in = b[i];
         repeat (bit_clks) @(posedge clk);
      end
      #1 rx_in = stop_bit;
      repeat (bit_clks) @(posedge clk);
      #1 rx_in = 1'b1;
      $display("sent frame %02h stop=%0b bit_clks=%0d", b, stop_bit, bit_clks);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0; choose = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", rx_valid); else pass_cnt++;
      total++; if (rx_data !== 8'h00) $display("FAIL reset_data got %02h want 00", rx_data); else pass_cnt++;
      total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %0b want 0", frame_err); else pass_cnt++;
      total++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %0b want 0", overrun); else pass_cnt++;
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic test_basic;
      int fe0, ov0, g0;
      fe0 = fe_cnt; ov0 = ov_cnt; g0 = got_q.size();
      exp_q.delete();
      choose = 2'b11; rx_ready = 1'b1;
      send_frame(8'h55, 16*D3, 1'b1, 1'b1);
      send_frame(8'hA3, 16*D3, 1'b1, 1'b1);
      send_frame(8'h96, 66, 1'b1, 1'b1);
      send_frame(8'h69, 62, 1'b1, 1'b1);
      repeat (100) @(posedge clk);
      @(negedge clk);
      total++;
      if (got_q.size() - g0 != exp_q.size()) $display("FAIL basic_count got %0d want %0d", got_q.size() - g0, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         total++;
         if (got_q[g0+i] !== exp_q[i]) $display("FAIL basic_byte%0d got %02h want %02h", i, got_q[g0+i], exp_q[i]);
         else pass_cnt++;
      end
      total++; if (fe_cnt != fe0) $display("FAIL basic_ferr got %0d want 0", fe_cnt - fe0); else pass_cnt++;
      total++; if (ov_cnt != ov0) $display("FAIL basic_ovr got %0d want 0", ov_cnt - ov0); else pass_cnt++;
   endtask

   task automatic test_false_start;
      int g0;
      g0 = got_q.size();
      exp_q.delete();
      choose = 2'b00; rx_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1 rx_in = 1'b0;
      repeat (4*D0) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (400) @(posedge clk);
      total++;
      if (got_q.size() != g0) $display("FAIL glitch_byte got %0d bytes want 0", got_q.size() - g0); else pass_cnt++;
      send_frame(8'h3C, 16*D0, 1'b1, 1'b1);
      repeat (100) @(posedge clk);
      @(negedge clk);
      total++;
      if (got_q.size() - g0 != 1) $display("FAIL false_start_count got %0d want 1", got_q.size() - g0);
      else pass_cnt++;
      if (got_q.size() > g0) begin
         total++;
         if (got_q[g0] !== exp_q[0]) $display("FAIL false_start_byte got %02h want %02h", got_q[g0], exp_q[0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_frame_err;
      int fe0, g0;
      fe0 = fe_cnt; g0 = got_q.size();
      exp_q.delete();
      choose = 2'b11; rx_ready = 1'b0;
      send_frame(8'h81, 16*D3, 1'b0, 1'b0);
      repeat (64) @(posedge clk);
      @(negedge clk);
      total++; if (fe_cnt - fe0 != 1) $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); else pass_cnt++;
      total++; if (rx_valid !== 1'b0) $display("FAIL ferr_valid got %0b want 0", rx_valid); else pass_cnt++;
      send_frame(8'h7E, 16*D3, 1'b1, 1'b1);
      repeat (100) @(posedge clk);
      @(negedge clk);
      total++; if (rx_data !== 8'h7E) $display("FAIL ferr_head got %02h want 7e", rx_data); else pass_cnt++;
      @(posedge clk); #1 rx_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (got_q.size() - g0 != 1) $display("FAIL ferr_count got %0d want 1", got_q.size() - g0);
      else pass_cnt++;
      if (got_q.size() > g0) begin
         total++;
         if (got_q[g0] !== exp_q[0]) $display("FAIL ferr_next_byte got %02h want %02h", got_q[g0], exp_q[0]);
         else pass_cnt++;
      end
      total++; if (fe_cnt - fe0 != 1) $display("FAIL ferr_total got %0d want 1", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_overrun;
      int ov0, g0;
      ov0 = ov_cnt; g0 = got_q.size();
      exp_q.delete();
      choose = 2'b11; rx_ready = 1'b0;
      for (int k = 1; k <= 5; k++)
         send_frame(8'(k), 16*D3, 1'b1, k <= 4);
      pop_off = ov_cyc - last_start;
      repeat (50) @(posedge clk);
      @(negedge clk);
      total++; if (ov_cnt - ov0 != 1) $display("FAIL ovr_pulses got %0d want 1", ov_cnt - ov0); else pass_cnt++;
      total++; if (rx_data !== 8'h01) $display("FAIL ovr_head got %02h want 01", rx_data); else pass_cnt++;
      @(posedge clk); #1 rx_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained_valid got %0b want 0", rx_valid); else pass_cnt++;
      total++;
      if (got_q.size() - g0 != exp_q.size()) $display("FAIL ovr_count got %0d want %0d", got_q.size() - g0, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         total++;
         if (got_q[g0+i] !== exp_q[i]) $display("FAIL ovr_byte%0d got %02h want %02h", i, got_q[g0+i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_full_pop;
      int ov0, g0, s, tgt;
      ov0 = ov_cnt; g0 = got_q.size();
      exp_q.delete();
      choose = 2'b11; rx_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         send_frame(8'h11 + 8'(k), 16*D3, 1'b1, 1'b1);
      // Pop lands on the push edge of the sixth byte, timed from the overrun seen earlier.
      fork
         send_frame(8'h16, 16*D3, 1'b1, 1'b1);
         begin
            @(posedge clk); #2;
            s = last_start;
            tgt = s + pop_off - 1;
            while (cyc < tgt) begin
               @(posedge clk); #1;
            end
            rx_ready = 1'b1;
            @(posedge clk); #1 rx_ready = 1'b0;
         end
      join
      repeat (50) @(posedge clk);
      @(negedge clk);
      total++; if (ov_cnt != ov0) $display("FAIL fullpop_ovr got %0d want 0", ov_cnt - ov0); else pass_cnt++;
      total++; if (rx_valid !== 1'b1) $display("FAIL fullpop_valid got %0b want 1", rx_valid); else pass_cnt++;
      @(posedge clk); #1 rx_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (got_q.size() - g0 != exp_q.size()) $display("FAIL fullpop_count got %0d want %0d", got_q.size() - g0, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         total++;
         if (got_q[g0+i] !== exp_q[i]) $display("FAIL fullpop_byte%0d got %02h want %02h", i, got_q[g0+i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_baud;
      int g0;
      logic [7:0] b;
      exp_q.delete();
      choose = 2'b11; rx_ready = 1'b0;
      send_frame(8'h5A, 16*D3, 1'b1, 1'b0);
      repeat (50) @(posedge clk);
      @(negedge clk);
      total++; if (rx_data !== 8'h5A) $display("FAIL prereset_head got %02h want 5a", rx_data); else pass_cnt++;
      // Partial frame 0xB4, reset in the middle of data bit 3.
      b = 8'hB4;
      @(posedge clk); #1 rx_in = 1'b0;
      repeat (16*D3) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1 rx_in = b[i];
         repeat (16*D3) @(posedge clk);
      end
      #1 rx_in = b[3];
      repeat (8*D3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if (rx_valid !== 1'b0) $display("FAIL midrst_valid got %0b want 0", rx_valid); else pass_cnt++;
      total++; if (rx_data !== 8'h00) $display("FAIL midrst_data got %02h want 00", rx_data); else pass_cnt++;
      total++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr got %0b want 0", frame_err); else pass_cnt++;
      total++; if (overrun !== 1'b0) $display("FAIL midrst_ovr got %0b want 0", overrun); else pass_cnt++;
      rx_in = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      g0 = got_q.size();
      rx_ready = 1'b1;
      send_frame(8'hC5, 16*D3, 1'b1, 1'b1);
      fork
         send_frame(8'hE7, 16*D3, 1'b1, 1'b1);
         begin
            repeat (16*D3*3 + 20) @(posedge clk);
            #1 choose = 2'b10;
         end
      join
      repeat (50) @(posedge clk);
      send_frame(8'h18, 16*D2, 1'b1, 1'b1);
      repeat (150) @(posedge clk);
      @(negedge clk);
      total++;
      if (got_q.size() - g0 != exp_q.size()) $display("FAIL rstbaud_count got %0d want %0d", got_q.size() - g0, exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         total++;
         if (got_q[g0+i] !== exp_q[i]) $display("FAIL rstbaud_byte%0d got %02h want %02h", i, got_q[g0+i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_false_start;
      test_frame_err;
      test_overrun;
      test_full_pop;
      test_reset_baud;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
